rsa_key_param_gen: RTL and testbench

- Stage directly downstream of the prime-table lookup stage.
- Consumes the two selected primes p and q from that stage's out1/out2.
- Drives that stage's in3 index to walk candidate public exponents e, and consumes its out3 value.
- Computes n = p*q and phi = (p-1)*(q-1), then selects the first candidate e with 1 < e < phi and phi mod e != 0. The result (n, phi, e) goes to the private-key (d) computation stage.

---
 rtl/rsa_key_param_gen.sv | 162 ++++++++++++++++
 tb/tb_rsa_key_param_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rsa_key_param_gen.sv
// RSA key parameter stage: multiplies the selected primes into n and phi, then walks
// the prime table for the first exponent e with 1 < e < phi that does not divide phi.
module rsa_key_param_gen #(
    parameter int W           = 12,
    parameter int IDX_W       = 7,
    parameter int E_START_IDX = 0,
    parameter int ROM_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [W-1:0]       p_in,
    input  logic [W-1:0]       q_in,
    input  logic [W-1:0]       e_in,
    output logic [IDX_W-1:0]   e_idx,
    output logic [2*W-1:0]     n_out,
    output logic [2*W-1:0]     phi_out,
    output logic [W-1:0]       e_out,
    output logic               busy,
    output logic               done,
    output logic               fail
);

    typedef enum logic [3:0] {
        S_IDLE, S_MUL, S_WAIT, S_CHK, S_DIV, S_EVAL, S_NEXT, S_DONE, S_FAIL
    } state_t;

    localparam int CNT_W = $clog2(2*W + ROM_LAT + 2);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(2*W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(ROM_LAT);
    localparam logic [W-1:0]     ONE       = W'(1);
    localparam logic [W-1:0]     TWO       = W'(2);

    state_t state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [2*W-1:0]   mc_n, mc_phi, acc_n, acc_phi;
    logic [W-1:0]     mp_n, mp_phi;
    logic [W-1:0]     e_r;
    logic [W:0]       rem;
    logic [2*W-1:0]   dvd;

    logic             bad_pq, e_ok, last_idx, trial_ge;
    logic [2*W-1:0]   acc_n_nxt, acc_phi_nxt;
    logic [W:0]       trial, rem_nxt;

    assign bad_pq      = (p_in < TWO) || (q_in < TWO) || (p_in == q_in);
    assign e_ok        = (e_in > ONE) && ({{W{1'b0}}, e_in} < phi_out);
    assign last_idx    = (e_idx == {IDX_W{1'b1}});
    assign acc_n_nxt   = acc_n + (mp_n[0] ? mc_n : '0);
    assign acc_phi_nxt = acc_phi + (mp_phi[0] ? mc_phi : '0);

    // Restoring step: the partial remainder is always < e, so W+1 bits hold the trial.
    assign trial    = {rem[W-1:0], dvd[2*W-1]};
    assign trial_ge = (trial >= {1'b0, e_r});
    assign rem_nxt  = trial_ge ? (trial - {1'b0, e_r}) : trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = bad_pq ? S_FAIL : S_MUL;
            S_MUL:  if (cnt == MUL_LAST) next_state = S_WAIT;
            S_WAIT: if (cnt == WAIT_LAST) next_state = S_CHK;
            S_CHK:  next_state = e_ok ? S_DIV : S_NEXT;
            S_DIV:  if (cnt == DIV_LAST) next_state = S_EVAL;
            S_EVAL: next_state = (rem != '0) ? S_DONE : S_NEXT;
            S_NEXT: next_state = last_idx ? S_FAIL : S_WAIT;
            S_DONE: next_state = S_IDLE;
            S_FAIL: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mc_n    <= '0;
            mc_phi  <= '0;
            mp_n    <= '0;
            mp_phi  <= '0;
            acc_n   <= '0;
            acc_phi <= '0;
            e_r     <= '0;
            rem     <= '0;
            dvd     <= '0;
            e_idx   <= IDX_W'(E_START_IDX);
            n_out   <= '0;
            phi_out <= '0;
            e_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    // Previous results are dropped so a rejected p/q reports n=phi=0.
                    mc_n    <= {{W{1'b0}}, p_in};
                    mc_phi  <= {{W{1'b0}}, p_in - ONE};
                    mp_n    <= q_in;
                    mp_phi  <= q_in - ONE;
                    acc_n   <= '0;
                    acc_phi <= '0;
                    cnt     <= '0;
                    n_out   <= '0;
                    phi_out <= '0;
                    e_idx   <= IDX_W'(E_START_IDX);
                    busy    <= 1'b1;
                    done    <= 1'b0;
                    fail    <= 1'b0;
                end
                S_MUL: begin
                    acc_n   <= acc_n_nxt;
                    acc_phi <= acc_phi_nxt;
                    mc_n    <= mc_n << 1;
                    mc_phi  <= mc_phi << 1;
                    mp_n    <= mp_n >> 1;
                    mp_phi  <= mp_phi >> 1;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == MUL_LAST) begin
                        n_out   <= acc_n_nxt;
                        phi_out <= acc_phi_nxt;
                        cnt     <= '0;
                    end
                end
                S_WAIT: cnt <= (cnt == WAIT_LAST) ? '0 : cnt + CNT_W'(1);
                S_CHK: begin
                    e_r <= e_in;
                    rem <= '0;
                    dvd <= phi_out;
                    cnt <= '0;
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    dvd <= dvd << 1;
                    cnt <= cnt + CNT_W'(1);
                end
                S_EVAL: if (rem != '0) e_out <= e_r;
                S_NEXT: begin
                    cnt <= '0;
                    if (!last_idx) e_idx <= e_idx + IDX_W'(1);
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                S_FAIL: begin
                    fail  <= 1'b1;
                    busy  <= 1'b0;
                    e_out <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_key_param_gen.sv
// Directed bench for rsa_key_param_gen with a registered prime-table model on e_idx/e_in.
module tb_rsa_key_param_gen;

    localparam int W     = 12;
    localparam int IDX_W = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [W-1:0]       p_in = '0;
    logic [W-1:0]       q_in = '0;
    logic [W-1:0]       e_in = '0;
    logic [IDX_W-1:0]   e_idx;
    logic [2*W-1:0]     n_out;
    logic [2*W-1:0]     phi_out;
    logic [W-1:0]       e_out;
    logic               busy;
    logic               done;
    logic               fail;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] rom [128];

    rsa_key_param_gen #(.W(W), .IDX_W(IDX_W), .E_START_IDX(0), .ROM_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .p_in(p_in), .q_in(q_in), .e_in(e_in),
        .e_idx(e_idx), .n_out(n_out), .phi_out(phi_out), .e_out(e_out),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    // One-cycle registered table read, like the upstream prime table.
    always @(posedge clk) e_in <= rom[e_idx];

    function automatic bit is_prime(input int v);
        for (int d = 2; d * d <= v; d++) if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic fill_primes();
        int k = 0;
        for (int v = 2; k < 128; v++) begin
            if (is_prime(v)) begin
                rom[k] = W'(v);
                k++;
            end
        end
    endtask

    task automatic fill_threes();
        for (int i = 0; i < 128; i++) rom[i] = W'(3);
    endtask

    // Start edge is the posedge between the two negedges; returns just after it.
    task automatic do_start(input logic [W-1:0] p, input logic [W-1:0] q);
        @(negedge clk);
        p_in  = p;
        q_in  = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output int cyc, output logic busy_before);
        cyc = 0;
        busy_before = 1'b0;
        while (!(done || fail) && cyc < limit) begin
            busy_before = busy;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL reset_flags: got done=%0b fail=%0b want 0 0", done, fail); end
        total++; if (n_out !== '0 || phi_out !== '0 || e_out !== '0) begin bad++; $display("FAIL reset_data: got n=%0d phi=%0d e=%0d want 0 0 0", n_out, phi_out, e_out); end
        total++; if (e_idx !== '0) begin bad++; $display("FAIL reset_idx: got %0d want 0", e_idx); end
        rst = 1'b0;
    endtask

    task automatic test_equal_primes();
        int cyc;
        logic bb;
        do_start(12'd17, 12'd17);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL eq_busy: got %0b want 1", busy); end
        wait_end(20, cyc, bb);
        total++; if (cyc !== 1) begin bad++; $display("FAIL eq_latency: got %0d want 1", cyc); end
        total++; if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL eq_flags: got fail=%0b done=%0b busy=%0b want 1 0 0", fail, done, busy); end
        total++; if (n_out !== '0 || phi_out !== '0) begin bad++; $display("FAIL eq_data: got n=%0d phi=%0d want 0 0", n_out, phi_out); end
    endtask

    task automatic test_main();
        int cyc;
        logic bb;
        do_start(12'd61, 12'd53);
        total++; if (busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL main_start: got busy=%0b done=%0b fail=%0b want 1 0 0", busy, done, fail); end
        wait_end(400, cyc, bb);
        total++; if (cyc !== 128) begin bad++; $display("FAIL main_latency: got %0d want 128", cyc); end
        total++; if (n_out !== 24'd3233) begin bad++; $display("FAIL main_n: got %0d want 3233", n_out); end
        total++; if (phi_out !== 24'd3120) begin bad++; $display("FAIL main_phi: got %0d want 3120", phi_out); end
        total++; if (e_out !== 12'd7 || e_idx !== 7'd3) begin bad++; $display("FAIL main_e: got e=%0d idx=%0d want 7 3", e_out, e_idx); end
        total++; if (done !== 1'b1 || fail !== 1'b0) begin bad++; $display("FAIL main_flags: got done=%0b fail=%0b want 1 0", done, fail); end
        total++; if (busy !== 1'b0 || bb !== 1'b1) begin bad++; $display("FAIL main_busy_edge: got busy=%0b prior=%0b want 0 1", busy, bb); end
        @(negedge clk);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL main_done_level: got %0b want 1", done); end
    endtask

    task automatic test_small();
        int cyc;
        logic bb;
        do_start(12'd11, 12'd13);
        wait_end(400, cyc, bb);
        total++; if (n_out !== 24'd143 || phi_out !== 24'd120) begin bad++; $display("FAIL small_n_phi: got n=%0d phi=%0d want 143 120", n_out, phi_out); end
        total++; if (e_out !== 12'd7 || done !== 1'b1) begin bad++; $display("FAIL small_e: got e=%0d done=%0b want 7 1", e_out, done); end
        total++; if (cyc !== 128) begin bad++; $display("FAIL small_latency: got %0d want 128", cyc); end
    endtask

    task automatic test_exhaust();
        int cyc;
        logic bb;
        fill_threes();
        do_start(12'd7, 12'd13);
        wait_end(5000, cyc, bb);
        total++; if (cyc !== 3725) begin bad++; $display("FAIL exh_latency: got %0d want 3725", cyc); end
        total++; if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL exh_flags: got fail=%0b done=%0b busy=%0b want 1 0 0", fail, done, busy); end
        total++; if (e_idx !== 7'd127 || e_out !== '0) begin bad++; $display("FAIL exh_idx_e: got idx=%0d e=%0d want 127 0", e_idx, e_out); end
        total++; if (n_out !== 24'd91 || phi_out !== 24'd72) begin bad++; $display("FAIL exh_n_phi: got n=%0d phi=%0d want 91 72", n_out, phi_out); end
        fill_primes();
    endtask

    task automatic test_start_ignored();
        int cyc;
        logic bb;
        do_start(12'd61, 12'd53);
        repeat (18) @(negedge clk);
        do_start(12'd5, 12'd7);
        wait_end(400, cyc, bb);
        total++; if (cyc !== 108) begin bad++; $display("FAIL ign_latency: got %0d want 108", cyc); end
        total++; if (e_out !== 12'd7 || done !== 1'b1) begin bad++; $display("FAIL ign_e: got e=%0d done=%0b want 7 1", e_out, done); end
        total++; if (n_out !== 24'd3233 || phi_out !== 24'd3120) begin bad++; $display("FAIL ign_n_phi: got n=%0d phi=%0d want 3233 3120", n_out, phi_out); end
    endtask

    task automatic test_reset_mid_div();
        int cyc;
        logic bb;
        do_start(12'd61, 12'd53);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL rst_async_flags: got busy=%0b done=%0b fail=%0b want 0 0 0", busy, done, fail); end
        total++; if (n_out !== '0 || phi_out !== '0 || e_out !== '0) begin bad++; $display("FAIL rst_async_data: got n=%0d phi=%0d e=%0d want 0 0 0", n_out, phi_out, e_out); end
        total++; if (e_idx !== '0) begin bad++; $display("FAIL rst_async_idx: got %0d want 0", e_idx); end
        @(negedge clk);
        rst = 1'b0;
        do_start(12'd11, 12'd13);
        wait_end(400, cyc, bb);
        total++; if (cyc !== 128 || done !== 1'b1) begin bad++; $display("FAIL rst_rerun: got cyc=%0d done=%0b want 128 1", cyc, done); end
        total++; if (e_out !== 12'd7 || n_out !== 24'd143) begin bad++; $display("FAIL rst_rerun_data: got e=%0d n=%0d want 7 143", e_out, n_out); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic bb;
        do_start(12'd11, 12'd13);
        wait_end(400, cyc, bb);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_first_done: got %0b want 1", done); end
        do_start(12'd1, 12'd13);
        total++; if (done !== 1'b0 || fail !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_clear: got done=%0b fail=%0b busy=%0b want 0 0 1", done, fail, busy); end
        @(negedge clk);
        total++; if (fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_fail: got fail=%0b done=%0b busy=%0b want 1 0 0", fail, done, busy); end
        total++; if (e_out !== '0) begin bad++; $display("FAIL b2b_e: got %0d want 0", e_out); end
    endtask

    initial begin
        fill_primes();
        test_reset();
        test_equal_primes();
        test_main();
        test_small();
        test_exhaust();
        test_start_ignored();
        test_reset_mid_div();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
